// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl -- EX-stage sequencer in front of the iterative divider.
//
// Accepts a DIV/DIVU/REM/REMU from EX and latches its operands. It then either
// resolves the result locally or hands the operands to the divider. Local
// resolution covers divide-by-zero, signed overflow, and a hit in the
// last-result companion cache. EX is stalled until a result exists. The result
// is then presented for exactly one cycle.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   pipe_flush          kill any in-flight op (active-high)
//   ex_div_valid        EX holds a div-class op (held high while stalled)
//   ex_funct3           100 DIV, 101 DIVU, 110 REM, 111 REMU
//   ex_rs1/ex_rs2/ex_rd dividend, divisor, destination register
//   ex_div_stall        freeze IF/ID/EX
//   div_req             run request to the divider
//   div_sign            signed operation
//   div_dividend/div_divisor   latched operands
//   div_res_sel         1 = remainder, 0 = quotient
//   div_done/div_res    divider result strobe and value
//   res_valid/res_rd/res_data  one-cycle writeback
// -----------------------------------------------------------------------------
module div_ctrl #(
   parameter int XLEN     = 32,
   parameter int CACHE_EN = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_flush,
   input  logic            ex_div_valid,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [4:0]      ex_rd,
   output logic            ex_div_stall,
   output logic            div_req,
   output logic            div_sign,
   output logic [XLEN-1:0] div_dividend,
   output logic [XLEN-1:0] div_divisor,
   output logic            div_res_sel,
   input  logic            div_done,
   input  logic [XLEN-1:0] div_res,
   output logic            res_valid,
   output logic [4:0]      res_rd,
   output logic [XLEN-1:0] res_data
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic            CACHE_ON = (CACHE_EN != 0);

   state_e          state_q, state_d;

   // Latched operation
   logic [XLEN-1:0] rs1_q, rs2_q, res_q;
   logic [4:0]      rd_q;
   logic            sign_q, sel_q;
   logic            ran_q;          // current DONE was reached through the divider

   // Last-result companion cache
   logic            c_valid;
   logic [XLEN-1:0] c_rs1, c_rs2, c_quo, c_rem;
   logic            c_sign;

   logic            ex_sign, ex_sel, div_zero, overflow, cache_hit, fast_path;
   logic            accept, capture, fill;
   logic [XLEN-1:0] fast_res;
   logic            unused_f3;

   // funct3[2] is always set for div-class ops; only bits [1:0] select behaviour.
   assign unused_f3 = ex_funct3[2];
   assign ex_sign   = ~ex_funct3[0];
   assign ex_sel    = ex_funct3[1];

   assign div_zero  = (ex_rs2 == '0);
   assign overflow  = ex_sign && (ex_rs1 == INT_MIN) && (ex_rs2 == '1);
   assign cache_hit = CACHE_ON && c_valid && (c_rs1 == ex_rs1) &&
                      (c_rs2 == ex_rs2) && (c_sign == ex_sign);
   assign fast_path = div_zero || overflow || cache_hit;

   // Result of any op that does not need the divider; priority matters because
   // a zero divisor never reaches the overflow or cache checks.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      fast_res = '0;
      if (div_zero)       fast_res = ex_sel ? ex_rs1 : '1;
      else if (overflow)  fast_res = ex_sel ? '0 : INT_MIN;
      else if (cache_hit) fast_res = ex_sel ? c_rem : c_quo;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_div_valid && !pipe_flush) begin
               accept  = 1'b1;
               state_d = fast_path ? DONE : RUN;
            end
         end
         RUN: begin
            if (pipe_flush)    state_d = IDLE;
            else if (div_done) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign capture = (state_q == RUN) && !pipe_flush && div_done;
   // A flushed DONE may still fill: the stored pair is architecturally correct.
   assign fill    = (state_q == DONE) && ran_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         sign_q  <= 1'b0;
         sel_q   <= 1'b0;
         res_q   <= '0;
         ran_q   <= 1'b0;
         c_valid <= 1'b0;
      end else begin
         if (accept) begin
            rs1_q  <= ex_rs1;
            rs2_q  <= ex_rs2;
            rd_q   <= ex_rd;
            sign_q <= ex_sign;
            sel_q  <= ex_sel;
            res_q  <= fast_res;
            ran_q  <= 1'b0;
         end
         if (capture) begin
            res_q <= div_res;
            ran_q <= 1'b1;
         end
         if (fill) c_valid <= CACHE_ON;
      end
   end

   // NOTE: cache payload has no reset; c_valid alone guards it, saving reset fan-out.
   // In DONE after a divider run, div_res carries the companion (~sel) value.
   always_ff @(posedge clk) begin
      if (fill) begin
         c_rs1  <= rs1_q;
         c_rs2  <= rs2_q;
         c_sign <= sign_q;
         c_quo  <= sel_q ? div_res : res_q;
         c_rem  <= sel_q ? res_q   : div_res;
      end
   end

   assign ex_div_stall = ex_div_valid && (state_q != DONE);
   assign div_req      = (state_q == RUN) && !pipe_flush;
   assign div_sign     = sign_q;
   assign div_dividend = rs1_q;
   assign div_divisor  = rs2_q;
   assign div_res_sel  = fill ? ~sel_q : sel_q;
   assign res_valid    = (state_q == DONE) && !pipe_flush;
   assign res_rd       = rd_q;
   assign res_data     = res_q;

   // EX must hold its instruction for the whole divider run unless flushed.
   a_valid_held_in_run: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == RUN && !pipe_flush) |-> ex_div_valid);

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl -- scoreboard bench for div_ctrl.
// Stimulus pushes the hand-computed result into exp_q. A monitor pops and
// compares whenever res_valid is seen. The stimulus tasks separately check
// latency, stall length and divider request length.
// -----------------------------------------------------------------------------
module tb_div_ctrl;
   localparam int XLEN = 32;

   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            pipe_flush = 1'b0;
   logic            ex_div_valid = 1'b0;
   logic [2:0]      ex_funct3 = '0;
   logic [XLEN-1:0] ex_rs1 = '0;
   logic [XLEN-1:0] ex_rs2 = '0;
   logic [4:0]      ex_rd = '0;
   logic            ex_div_stall, div_req, div_sign, div_res_sel, div_done;
   logic [XLEN-1:0] div_dividend, div_divisor, div_res;
   logic            res_valid;
   logic [4:0]      res_rd;
   logic [XLEN-1:0] res_data;

   always #5 clk = ~clk;

   div_ctrl #(.XLEN(XLEN), .CACHE_EN(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pipe_flush   (pipe_flush),
      .ex_div_valid (ex_div_valid),
      .ex_funct3    (ex_funct3),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_rd        (ex_rd),
      .ex_div_stall (ex_div_stall),
      .div_req      (div_req),
      .div_sign     (div_sign),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_res_sel  (div_res_sel),
      .div_done     (div_done),
      .div_res      (div_res),
      .res_valid    (res_valid),
      .res_rd       (res_rd),
      .res_data     (res_data)
   );

   // Divider model: done in the 34th consecutive cycle of div_req; result
   // follows div_res_sel combinationally from the held operands.
   logic [5:0]      dcnt = '0;
   logic [XLEN-1:0] m_quo, m_rem;

   always @(posedge clk) dcnt <= div_req ? dcnt + 6'd1 : 6'd0;
   assign div_done = div_req && (dcnt == 6'd33);

   always_comb begin
      m_quo = '0;
      m_rem = '0;
      if (div_divisor != '0) begin
         if (div_sign) begin
            m_quo = XLEN'($signed(div_dividend) / $signed(div_divisor));
            m_rem = XLEN'($signed(div_dividend) % $signed(div_divisor));
         end else begin
            m_quo = div_dividend / div_divisor;
            m_rem = div_dividend % div_divisor;
         end
      end
   end
   assign div_res = div_res_sel ? m_rem : m_quo;

   // Scoreboard
   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (res_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got rd=%0d data=0x%0h, expected no result",
                     res_rd, res_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("result rd%0d", e.rd), 64'({res_rd, res_data}), 64'({e.rd, e.data}));
         end
      end
   end

   task automatic drive_op(input logic [2:0] f3, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [4:0] rd);
      @(posedge clk);
      #1;
      ex_div_valid = 1'b1;
      ex_funct3    = f3;
      ex_rs1       = a;
      ex_rs2       = b;
      ex_rd        = rd;
   endtask

   // Issues one op and returns at the falling edge of its res_valid cycle,
   // leaving ex_div_valid high so a following op can be back-to-back.
   task automatic run_op(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [4:0] rd,
                         input logic [XLEN-1:0] exp, input int exp_lat);
      int lat    = 0;
      int stalls = 0;
      int reqs   = 0;
      exp_t e;
      e.rd   = rd;
      e.data = exp;
      exp_q.push_back(e);
      drive_op(f3, a, b, rd);
      for (int c = 1; c <= 100 && lat == 0; c++) begin
         @(negedge clk);
         if (ex_div_stall) stalls++;
         if (div_req)      reqs++;
         if (res_valid)    lat = c;
      end
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " stall_cycles"}, 64'(stalls), 64'(exp_lat - 1));
      check({name, " div_req_cycles"}, 64'(reqs), (exp_lat == 36) ? 64'd34 : 64'd0);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
      ex_div_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " ex_div_stall"}, 64'(ex_div_stall), 64'd0);
      check({tag, " div_req"},      64'(div_req),      64'd0);
      check({tag, " res_valid"},    64'(res_valid),    64'd0);
      check({tag, " res_data"},     64'(res_data),     64'd0);
      check({tag, " res_rd"},       64'(res_rd),       64'd0);
      check({tag, " div_dividend"}, 64'(div_dividend), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Divider path
      run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 36);
      idle_cycle();

      // DIV then REM on identical operands: REM comes from the cache
      run_op("div_m100_7", F_DIV, -32'sd100, 32'd7, 5'd2, 32'hFFFF_FFF2, 36);
      run_op("rem_m100_7", F_REM, -32'sd100, 32'd7, 5'd3, 32'hFFFF_FFFE, 2);
      idle_cycle();

      // Divide by zero
      run_op("div_5_0",  F_DIV,  32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 2);
      run_op("remu_5_0", F_REMU, 32'd5, 32'd0, 5'd5, 32'd5, 2);
      idle_cycle();

      // Signed overflow; the unsigned version must use the divider
      run_op("div_ovf",  F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 2);
      run_op("rem_ovf",  F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, 2);
      run_op("divu_ovf", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 36);
      idle_cycle();

      // Flush at RUN cycle 10 (cycle 11 after issue)
      drive_op(F_DIVU, 32'd20, 32'd4, 5'd9);
      repeat (10) @(posedge clk);
      #1 pipe_flush = 1'b1;
      @(negedge clk);
      check("flush div_req same cycle", 64'(div_req), 64'd0);
      check("flush res_valid same cycle", 64'(res_valid), 64'd0);
      @(posedge clk);
      #1;
      pipe_flush   = 1'b0;
      ex_div_valid = 1'b0;
      @(negedge clk);
      check("post_flush div_req", 64'(div_req), 64'd0);
      check("post_flush res_valid", 64'(res_valid), 64'd0);
      check("post_flush stall", 64'(ex_div_stall), 64'd0);
      run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 5'd10, 32'd3, 36);
      run_op("remu_9_3_hit", F_REMU, 32'd9, 32'd3, 5'd11, 32'd0, 2);
      idle_cycle();

      // Reset for one cycle mid-RUN, then the cached operands must miss
      drive_op(F_DIVU, 32'd1000, 32'd10, 5'd12);
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      ex_div_valid = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_run_reset");
      run_op("divu_9_3_after_reset", F_DIVU, 32'd9, 32'd3, 5'd13, 32'd3, 36);
      idle_cycle();

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- EX-stage sequencer that sits directly upstream of the iterative divider.
- Accepts an M-extension DIV/DIVU/REM/REMU from EX, latches the operands and drives the divider handshake.
- Stalls the pipeline until a result exists, then presents that result to EX/MEM for one cycle.
- Resolves divide-by-zero, signed overflow and a DIV/REM pair on identical operands without running the divider.

Parameters:
- XLEN, 32: operand/result width.
- CACHE_EN, 1: 1 enables the last-result companion cache; 0 disables hits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- pipe_flush  in  1  kill in-flight op (same FLUSH polarity as rest of core, active-high)
- ex_div_valid  in  1  EX holds a div-class instruction; held high while stalled
- ex_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- ex_rs1  in  XLEN  dividend
- ex_rs2  in  XLEN  divisor
- ex_rd  in  5  destination register
- ex_div_stall  out  1  to hazard unit; freezes IF/ID/EX
- div_req  out  1  to divider's ex_is_div_inst
- div_sign  out  1  signed op (~funct3[0])
- div_dividend  out  XLEN  latched rs1
- div_divisor  out  XLEN  latched rs2
- div_res_sel  out  1  1 = remainder, 0 = quotient
- div_done  in  1  divider result valid this cycle
- div_res  in  XLEN  divider result
- res_valid  out  1  one-cycle writeback strobe
- res_rd  out  5  destination of res_data
- res_data  out  XLEN  final result

Behaviour:
- Reset: state IDLE; cache invalid; latched regs 0.
- Reset values of outputs: ex_div_stall=0 (when ex_div_valid=0), div_req=0, res_valid=0, res_data=0, res_rd=0.
- States: IDLE, RUN, DONE.
- IDLE, when ex_div_valid & ~pipe_flush:
  - Latch rs1, rs2, rd, sign=~f3[0], sel=f3[1].
  - Divisor==0: quotient = all ones; remainder = rs1. Go to DONE.
  - Signed & rs1==0x8000_0000 & rs2==all ones: quotient = 0x8000_0000; remainder = 0. Go to DONE.
  - Cache hit (CACHE_EN, cache valid, same rs1/rs2/sign): result = stored value for sel. Go to DONE.
  - Otherwise go to RUN.
- RUN:
  - div_req=1, driving the latched operands, sign and sel.
  - On div_done: capture div_res into the result reg; go to DONE.
  - The divider asserts div_done in the 34th consecutive RUN cycle.
- DONE:
  - res_valid = ~pipe_flush; res_rd and res_data are the latched values.
  - div_req=0. Operands and sign stay held.
  - If entered from RUN: div_res_sel = ~sel and div_res is captured as the companion value. Cache stores {rs1, rs2, sign, quotient, remainder} and is marked valid (if CACHE_EN).
  - Always go to IDLE next cycle.
- ex_div_stall = ex_div_valid & (state != DONE).
  - Stall lasts 1 cycle in IDLE plus all RUN cycles; it drops in DONE so EX advances at the end of DONE.
- Latency, ex_div_valid rising to res_valid:
  - 36 cycles on the divider path.
  - 2 cycles on a fast path or cache hit.
- div_req deasserts in DONE, so the divider's counter returns to 0 before any back-to-back op.
- pipe_flush in any state: go to IDLE next cycle; div_req=0 that same cycle; res_valid=0.
  - Cache fill in a flushed DONE is still allowed, since the stored values are correct.
  - Flush in IDLE blocks acceptance.
- ex_div_valid dropping while in RUN without a flush is illegal; assert in simulation.
- Cache invalidated only by reset. With CACHE_EN=0 the valid bit is forced to 0.
- All arithmetic is XLEN-bit; comparisons are exact bitwise.

Test Plan:
- DIVU 100/7 -> ex_div_stall high for 35 cycles; res_valid in cycle 36 with res_data=14; div_req high for exactly 34 cycles.
- DIV -100/7, then REM -100/7 back-to-back:
  - DIV -> 0xFFFF_FFF2 after 36 cycles.
  - REM -> 0xFFFF_FFFE after 2 cycles, with div_req never asserted for it.
- DIV 5/0 -> 0xFFFF_FFFF. REMU 5/0 -> 5. Each takes 2 cycles with div_req=0.
- DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000. REM on the same operands -> 0. Each takes 2 cycles.
- pipe_flush asserted at RUN cycle 10:
  - Next cycle: state IDLE, div_req=0, no res_valid.
  - A new DIVU 9/3 then yields 3 after 36 cycles.
- rst_n low for 1 cycle mid-RUN -> all outputs at reset values next cycle; cache miss on a repeat of the same operands (full 36 cycles).
